// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-enable divider: channel mode,
// packed channel configuration and the integer-mode duty threshold.
package clk_div_pkg;

    localparam int DIV_W_MAX = 32;

    typedef enum logic {
        INT  = 1'b0,
        FRAC = 1'b1
    } div_mode_e;

    typedef struct packed {
        logic                 en;
        div_mode_e            mode;
        logic [DIV_W_MAX-1:0] div;
    } chan_cfg_t;

    // Phase stays high while the counter is below ceil(D/2), with D = max(div, 1)
    function automatic logic [DIV_W_MAX:0] dutyThreshold(input logic [DIV_W_MAX-1:0] div);
        logic [DIV_W_MAX:0] d;
        d = (div == '0) ? (DIV_W_MAX+1)'(1) : {1'b0, div};
        return (d + (DIV_W_MAX+1)'(1)) >> 1;
    endfunction

endpackage

// File: rtl/clk_en_div_if.sv
// Configuration write port of the clock-enable divider: valid/ready handshake
// carrying target channel, enable, mode and divide value.
interface clk_en_div_if #(
    parameter int NCH   = 2,
    parameter int DIV_W = 16
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic             cfg_en;
    logic             cfg_mode;
    logic [DIV_W-1:0] cfg_div;

    modport master (
        output cfg_valid, cfg_ch, cfg_en, cfg_mode, cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_en, cfg_mode, cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: shadow config applied on a tick boundary, integer
// counter or fractional accumulator, registered tick/phase and lock tracking.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int LOCK_TICKS = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wrEn_i,
    input  chan_cfg_t wrCfg_i,
    input  logic      align_i,
    output logic      pending_o,
    output logic      tick_o,
    output logic      phase_o,
    output logic      locked_o
);

    localparam int LK_W = $clog2(LOCK_TICKS + 1);

    chan_cfg_t            shadow_q, shadow_d;
    chan_cfg_t            active_q, active_d;
    logic                 pending_q, pending_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [LK_W-1:0]      lockCnt_q, lockCnt_d;
    logic                 tick_q, tick_d;
    logic                 phase_q, phase_d;
    logic                 locked_q, locked_d;

    logic [DIV_W_MAX-1:0] effDiv;
    logic [DIV_W:0]       fracSum;
    logic                 tickCond;
    logic                 apply;

    // The wrap condition doubles as the apply point for an enabled channel
    always_comb begin
        effDiv   = (active_q.div == '0) ? DIV_W_MAX'(1) : active_q.div;
        fracSum  = {1'b0, cnt_q} + {1'b0, active_q.div[DIV_W-1:0]};
        tickCond = 1'b0;
        if (active_q.en) begin
            if (active_q.mode == FRAC) begin
                tickCond = fracSum[DIV_W];
            end else begin
                tickCond = (DIV_W_MAX'(cnt_q) == effDiv - DIV_W_MAX'(1));
            end
        end
        apply = pending_q & (~active_q.en | tickCond);
    end

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        cnt_d     = '0;
        lockCnt_d = lockCnt_q;
        tick_d    = tickCond;
        phase_d   = 1'b0;
        locked_d  = active_q.en & (lockCnt_q == LK_W'(LOCK_TICKS));

        if (active_q.en) begin
            if (active_q.mode == FRAC) begin
                phase_d = cnt_q[DIV_W-1];
                cnt_d   = fracSum[DIV_W-1:0];
            end else begin
                phase_d = {1'b0, DIV_W_MAX'(cnt_q)} < dutyThreshold(active_q.div);
                cnt_d   = tickCond ? '0 : cnt_q + DIV_W'(1);
            end
            if (tickCond && (lockCnt_q != LK_W'(LOCK_TICKS))) begin
                lockCnt_d = lockCnt_q + LK_W'(1);
            end
            if (align_i) begin
                cnt_d     = '0;
                tick_d    = 1'b0;
                lockCnt_d = lockCnt_q;
            end
        end

        if (wrEn_i) begin
            shadow_d  = wrCfg_i;
            pending_d = 1'b1;
        end

        // Apply wins over align: same datapath restart, but lock is also cleared
        if (apply) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
            cnt_d     = '0;
            lockCnt_d = '0;
            tick_d    = tickCond;
            locked_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            lockCnt_q <= '0;
            tick_q    <= 1'b0;
            phase_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            lockCnt_q <= lockCnt_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
            locked_q  <= locked_d;
        end
    end

    assign pending_o = pending_q;
    assign tick_o    = tick_q;
    assign phase_o   = phase_q;
    assign locked_o  = locked_q;

endmodule

// File: rtl/clk_en_div.sv
// Multi-channel runtime-programmable clock-enable generator: config handshake
// decode and align fan-out around NCH independent divider channels.
module clk_en_div
    import clk_div_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int DIV_W      = 16,
    parameter int LOCK_TICKS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    clk_en_div_if.slave     cfg,
    input  logic            align,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  phase,
    output logic [NCH-1:0]  locked
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] pending;
    logic [NCH-1:0] wrEn;
    logic           cfgReady;
    chan_cfg_t      wrCfg;

    // Out-of-range channel numbers stay ready so their writes complete and drop
    always_comb begin
        cfgReady = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                cfgReady = ~pending[i];
            end
        end
    end

    always_comb begin
        wrCfg.en   = cfg.cfg_en;
        wrCfg.mode = div_mode_e'(cfg.cfg_mode);
        wrCfg.div  = DIV_W_MAX'(cfg.cfg_div);
    end

    assign cfg.cfg_ready = cfgReady;

    for (genvar i = 0; i < NCH; i++) begin : gChan
        assign wrEn[i] = cfg.cfg_valid & cfgReady & (cfg.cfg_ch == CH_W'(i));

        clk_div_chan #(
            .DIV_W      (DIV_W),
            .LOCK_TICKS (LOCK_TICKS)
        ) uChan (
            .clk       (clk),
            .rst_n     (rst_n),
            .wrEn_i    (wrEn[i]),
            .wrCfg_i   (wrCfg),
            .align_i   (align),
            .pending_o (pending[i]),
            .tick_o    (tick[i]),
            .phase_o   (phase[i]),
            .locked_o  (locked[i])
        );
    end

endmodule
